// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings plus the state type and lane decode used by the
// on-chip SRAM responder.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} sram_slv_state_t;

   // Byte lanes touched by a transfer of the given size at the given offset.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] offs);
      case (size)
         HSIZE_BYTE:  return 4'b0001 << offs;
         HSIZE_HWORD: return offs[1] ? 4'b1100 : 4'b0011;
         default:     return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb3lite_sram_mem.sv
// Word-wide SRAM array with per-byte write enables and a registered read.
// A read and a write to the same word in one cycle return the old word.
module ahb3lite_sram_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   // NOTE: the array has no reset; clearing it would turn the RAM into flops.
   logic [31:0] r_mem [MEM_DEPTH];
   logic [31:0] r_rdata;

   // Byte-masked write and registered read of the addressed word.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we && i_be[i]) begin
            // NOTE: non-blocking, so the read below sees the pre-write contents.
            r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: programmable wait states, two-cycle ERROR,
// pipelined accepts and write-to-read bypass for back-to-back data phases.
module ahb3lite_sram_slave
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE  = 16,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int MEM_BYTES = 4 * MEM_DEPTH;

   sram_slv_state_t r_state;
   logic [3:0]      r_wait_cnt;
   logic            r_hreadyout;
   logic            r_hresp;

   logic [AW-1:0]   r_word;
   logic [3:0]      r_be;
   logic            r_write;

   logic            r_byp_valid;
   logic [AW-1:0]   r_byp_word;
   logic [3:0]      r_byp_be;
   logic [31:0]     r_byp_data;
   logic [31:0]     r_hrdata;

   logic            w_accept;
   logic            w_err;
   logic            w_mem_we;
   logic            w_rd_phase;
   logic [AW-1:0]   w_rd_word;
   logic [31:0]     w_mem_rdata;
   logic [31:0]     w_merged;
   logic            w_unused;

   // A new address phase is only taken while this slave is ready.
   assign w_accept   = HSEL & HREADY & HTRANS[1] & r_hreadyout;
   assign w_mem_we   = (r_state == DATA) & r_write & ~HRESET;
   assign w_rd_phase = (r_state == DATA) & ~r_write;
   assign w_rd_word  = w_accept ? HADDR[AW+1:2] : r_word;
   assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   // Address-phase error decode: range, unsupported size, misalignment.
   always_comb begin
      // NOTE: default first so every path assigns w_err and no latch forms.
      w_err = 1'b0;
      if (32'(HADDR) >= 32'(MEM_BYTES))                      w_err = 1'b1;
      if (HSIZE > HSIZE_WORD)                                w_err = 1'b1;
      if ((HSIZE == HSIZE_HWORD) && HADDR[0])                w_err = 1'b1;
      if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))    w_err = 1'b1;
   end

   // Response FSM with registered HREADYOUT/HRESP.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state     <= IDLE;
         r_wait_cnt  <= 4'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= HRESP_OKAY;
      end else begin
         case (r_state)
            WAIT: begin
               if (r_wait_cnt <= 4'd1) begin
                  r_state     <= DATA;
                  r_hreadyout <= 1'b1;
               end else begin
                  r_wait_cnt  <= r_wait_cnt - 4'd1;
               end
            end
            ERR1: begin
               r_state     <= ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= HRESP_ERROR;
            end
            default: begin
               if (w_accept && w_err) begin
                  r_state     <= ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= HRESP_ERROR;
               end else if (w_accept && (WAIT_STATES > 0)) begin
                  r_state     <= WAIT;
                  r_wait_cnt  <= 4'(WAIT_STATES);
                  r_hreadyout <= 1'b0;
                  r_hresp     <= HRESP_OKAY;
               end else if (w_accept) begin
                  r_state     <= DATA;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= HRESP_OKAY;
               end else begin
                  r_state     <= IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   // Latch word index, lanes and direction of each accepted OKAY transfer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_word  <= '0;
         r_be    <= 4'b0000;
         r_write <= 1'b0;
      end else if (w_accept && !w_err) begin
         r_word  <= HADDR[AW+1:2];
         r_be    <= byte_lanes(HSIZE, HADDR[1:0]);
         r_write <= HWRITE;
      end
   end

   // Remember the write committed on this edge; the read issued on the same
   // edge returned the old word and needs these bytes merged in.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_byp_valid <= 1'b0;
         r_byp_word  <= '0;
         r_byp_be    <= 4'b0000;
         r_byp_data  <= 32'd0;
      end else begin
         r_byp_valid <= w_mem_we;
         if (w_mem_we) begin
            r_byp_word <= r_word;
            r_byp_be   <= r_be;
            r_byp_data <= HWDATA;
         end
      end
   end

   // Overlay bypassed write bytes onto the word read from the array.
   always_comb begin
      w_merged = w_mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (r_byp_valid && (r_byp_word == r_word) && r_byp_be[i]) begin
            w_merged[8*i +: 8] = r_byp_data[8*i +: 8];
         end
      end
   end

   // Hold the last read word outside read data phases.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_hrdata <= 32'd0;
      end else if (w_rd_phase) begin
         r_hrdata <= w_merged;
      end
   end

   assign HRDATA    = w_rd_phase ? w_merged : r_hrdata;
   assign HREADYOUT = r_hreadyout;
   assign HRESP     = r_hresp;

   ahb3lite_sram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_mem (
      .i_clk   (HCLK),
      .i_we    (w_mem_we),
      .i_be    (r_be),
      .i_waddr (r_word),
      .i_wdata (HWDATA),
      .i_raddr (w_rd_word),
      .o_rdata (w_mem_rdata)
   );

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for the SRAM responder: one instance with no wait states and one with
// three. A driver issues pipelined transfers and queues expected responses
// from a byte-array model; per-instance monitors check each data phase.
module tb_ahb3lite_sram_slave;
   import ahb3lite_pkg::*;

   localparam int NDUT = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        hreset    [NDUT];
   logic        hsel      [NDUT];
   logic [15:0] haddr     [NDUT];
   logic [31:0] hwdata    [NDUT];
   logic [31:0] hrdata    [NDUT];
   logic        hwrite    [NDUT];
   logic [2:0]  hsize     [NDUT];
   logic [2:0]  hburst    [NDUT];
   logic [3:0]  hprot     [NDUT];
   logic [1:0]  htrans    [NDUT];
   logic        hmastlock [NDUT];
   logic        hreadyout [NDUT];
   logic        hresp     [NDUT];

   typedef struct {
      int          k;
      bit          wr;
      bit          err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb [$];
   logic [7:0]  mdl [NDUT][1024];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Access rules of the slave, stated directly.
   function automatic bit is_err(input logic [2:0] sz, input logic [15:0] a);
      if (int'(a) >= 1024) return 1'b1;
      if (sz > 3'd2) return 1'b1;
      if (sz == 3'd1 && a[0]) return 1'b1;
      if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] rd_word(input int k, input int a);
      int w = a & ~3;
      return {mdl[k][w+3], mdl[k][w+2], mdl[k][w+1], mdl[k][w]};
   endfunction

   task automatic wr_model(input int k, input logic [2:0] sz, input int a, input logic [31:0] wd);
      int n = 1 << sz;
      for (int i = 0; i < n; i++) mdl[k][a+i] = wd[8*((a+i)%4) +: 8];
   endtask

   genvar g;
   generate
      for (g = 0; g < NDUT; g++) begin : g_dut
         localparam int WS = (g == 0) ? 0 : 3;
         int   low = 0;
         bit   in_ph = 1'b0;
         logic first_resp = 1'b0;
         exp_t e;

         ahb3lite_sram_slave #(
            .HADDR_SIZE  (16),
            .HDATA_SIZE  (32),
            .MEM_DEPTH   (256),
            .WAIT_STATES (WS)
         ) u_dut (
            .HCLK      (clk),
            .HRESET    (hreset[g]),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (hburst[g]),
            .HPROT     (hprot[g]),
            .HTRANS    (htrans[g]),
            .HMASTLOCK (hmastlock[g]),
            .HREADY    (hreadyout[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g])
         );

         // Monitor: one observation per cycle, mid-cycle.
         always @(negedge clk) begin
            if (hreset[g] !== 1'b0) begin
               in_ph = 1'b0;
               low   = 0;
            end else begin
               if (in_ph) begin
                  if (hreadyout[g] === 1'b0) begin
                     low++;
                     if (low == 1) first_resp = hresp[g];
                     if (low > 40) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL dut%0d stall: HREADYOUT low %0d cycles, want %0d", g, low, WS);
                        in_ph = 1'b0;
                        low   = 0;
                     end
                  end else begin
                     if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL dut%0d spurious data phase: got completion, want none queued", g);
                     end else begin
                        e = sb.pop_front();
                        check($sformatf("dut%0d owner", g), 32'(g), 32'(e.k));
                        check($sformatf("dut%0d hresp", g), {31'd0, hresp[g]}, {31'd0, e.err});
                        check($sformatf("dut%0d wait cycles", g), 32'(low), e.err ? 32'd1 : 32'(WS));
                        if (e.err && low >= 1)
                           check($sformatf("dut%0d err first cycle hresp", g), {31'd0, first_resp}, 32'd1);
                        if (!e.wr && !e.err)
                           check($sformatf("dut%0d hrdata", g), hrdata[g], e.data);
                     end
                     low = 0;
                  end
               end else begin
                  check($sformatf("dut%0d idle hreadyout", g), {31'd0, hreadyout[g]}, 32'd1);
                  check($sformatf("dut%0d idle hresp", g), {31'd0, hresp[g]}, 32'd0);
               end
               in_ph = (in_ph && hreadyout[g] !== 1'b1) ||
                       (hsel[g] && htrans[g][1] && hreadyout[g] === 1'b1);
            end
         end
      end
   endgenerate

   // Wait (bounded) for the edge that takes the currently driven address phase.
   task automatic wait_accept(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (hreadyout[k] === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL dut%0d accept timeout: HREADYOUT stuck, want high within 64 cycles", k);
      end
   endtask

   // One address phase; its data phase is driven once it has been accepted.
   task automatic beat(input int k, input bit wr, input logic [2:0] sz, input logic [15:0] a,
                       input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] bu);
      exp_t ex;
      bit   ok;
      hsel[k]      = 1'b1;
      htrans[k]    = tr;
      haddr[k]     = a;
      hwrite[k]    = wr;
      hsize[k]     = sz;
      hburst[k]    = bu;
      hprot[k]     = 4'($urandom);
      hmastlock[k] = 1'b0;
      if (tr[1]) begin
         ex.k    = k;
         ex.wr   = wr;
         ex.err  = is_err(sz, a);
         ex.data = 32'd0;
         if (!ex.err) begin
            if (wr) wr_model(k, sz, int'(a), wd);
            else    ex.data = rd_word(k, int'(a));
         end
         sb.push_back(ex);
      end
      wait_accept(k, ok);
      hwdata[k] = wd;
   endtask

   task automatic idle_drain(input int k);
      bit ok;
      hsel[k]   = 1'b0;
      htrans[k] = HTRANS_IDLE;
      wait_accept(k, ok);
      for (int i = 0; i < 64; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check($sformatf("dut%0d drain", k), 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic init_mem(input int k);
      for (int w = 0; w < 64; w++)
         beat(k, 1'b1, HSIZE_WORD, 16'(4*w), $urandom, (w == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR);
      idle_drain(k);
   endtask

   task automatic rand_traffic(input int k, input int n);
      logic [2:0]  sz;
      logic [15:0] a;
      int          r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            beat(k, 1'b0, HSIZE_WORD, 16'd0, 32'd0, HTRANS_IDLE, HBURST_SINGLE);
         end else if (r <= 3) begin
            case ($urandom_range(0, 2))
               0:       begin sz = HSIZE_WORD;  a = 16'($urandom_range(1024, 65535)) & 16'hFFFC; end
               1:       begin sz = HSIZE_DWORD; a = 16'($urandom_range(0, 255)) & 16'hFFF8; end
               default: begin sz = HSIZE_HWORD; a = 16'($urandom_range(0, 255)) | 16'h0001; end
            endcase
            beat(k, 1'($urandom), sz, a, $urandom, HTRANS_NONSEQ, HBURST_SINGLE);
         end else begin
            sz = 3'($urandom_range(0, 2));
            a  = 16'($urandom_range(0, 255)) & ~16'((1 << sz) - 1);
            beat(k, 1'($urandom), sz, a, $urandom, (r % 2 == 0) ? HTRANS_SEQ : HTRANS_NONSEQ, HBURST_INCR);
         end
      end
      idle_drain(k);
   endtask

   initial begin
      bit ok;
      for (int k = 0; k < NDUT; k++) begin
         hreset[k]    = 1'b1;
         hsel[k]      = 1'b0;
         haddr[k]     = 16'd0;
         hwdata[k]    = 32'd0;
         hwrite[k]    = 1'b0;
         hsize[k]     = HSIZE_WORD;
         hburst[k]    = HBURST_SINGLE;
         hprot[k]     = 4'd0;
         htrans[k]    = HTRANS_IDLE;
         hmastlock[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) hreset[k] = 1'b0;

      // Reset state while idle.
      repeat (4) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d reset hreadyout", k), {31'd0, hreadyout[k]}, 32'd1);
            check($sformatf("dut%0d reset hresp", k), {31'd0, hresp[k]}, 32'd0);
            check($sformatf("dut%0d reset hrdata", k), hrdata[k], 32'd0);
         end
      end
      @(posedge clk);
      #1;

      // No wait states: bypass of a full word and of four byte writes.
      init_mem(0);
      beat(0, 1'b1, HSIZE_WORD, 16'h0010, 32'hDEADBEEF, HTRANS_NONSEQ, HBURST_SINGLE);
      beat(0, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
      beat(0, 1'b1, HSIZE_BYTE, 16'h0020, {4{8'h11}}, HTRANS_NONSEQ, HBURST_INCR4);
      beat(0, 1'b1, HSIZE_BYTE, 16'h0021, {4{8'h22}}, HTRANS_SEQ, HBURST_INCR4);
      beat(0, 1'b1, HSIZE_BYTE, 16'h0022, {4{8'h33}}, HTRANS_SEQ, HBURST_INCR4);
      beat(0, 1'b1, HSIZE_BYTE, 16'h0023, {4{8'h44}}, HTRANS_SEQ, HBURST_INCR4);
      beat(0, 1'b0, HSIZE_WORD, 16'h0020, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(0);
      rand_traffic(0, 150);

      // Three wait states: single read, INCR4 read, error responses.
      init_mem(1);
      beat(1, 1'b0, HSIZE_WORD, 16'h0000, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(1);
      for (int i = 0; i < 4; i++)
         beat(1, 1'b0, HSIZE_WORD, 16'(16'h0040 + 4*i), 32'h0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
      idle_drain(1);
      beat(1, 1'b0, HSIZE_WORD,  16'h0400, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(1);
      beat(1, 1'b1, HSIZE_HWORD, 16'h0003, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
      beat(1, 1'b1, HSIZE_DWORD, 16'h0000, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
      beat(1, 1'b0, HSIZE_WORD,  16'h0000, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(1);

      // Reset in the middle of a write's wait states discards the write.
      beat(1, 1'b1, HSIZE_WORD, 16'h0030, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(1);
      hsel[1]   = 1'b1;
      htrans[1] = HTRANS_NONSEQ;
      haddr[1]  = 16'h0030;
      hwrite[1] = 1'b1;
      hsize[1]  = HSIZE_WORD;
      wait_accept(1, ok);
      hsel[1]   = 1'b0;
      htrans[1] = HTRANS_IDLE;
      hwdata[1] = 32'hFFFFFFFF;
      hreset[1] = 1'b1;
      @(posedge clk);
      #1;
      hreset[1] = 1'b0;
      @(negedge clk);
      check("dut1 abort hreadyout", {31'd0, hreadyout[1]}, 32'd1);
      check("dut1 abort hresp", {31'd0, hresp[1]}, 32'd0);
      @(posedge clk);
      #1;
      beat(1, 1'b0, HSIZE_WORD, 16'h0030, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
      idle_drain(1);
      rand_traffic(1, 150);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
